// File: rtl/nnrv_mem_arb.sv
// Single-port RAM arbiter between instruction fetch (IF) and load/store (MEM).
// Optional IF anti-starvation promotion enabled by defining NNRV_MEM_ARB_STARVE_EN.
module nnrv_mem_arb #(
  parameter int ADDR_WIDTH   = 8,
  parameter int XLEN         = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_if_req,
  input  logic [ADDR_WIDTH-1:0] i_if_addr,
  output logic                  o_if_gnt,
  output logic                  o_if_rvalid,
  output logic [XLEN-1:0]       o_if_rdata,
  input  logic                  i_mem_req,
  input  logic                  i_mem_we,
  input  logic [ADDR_WIDTH-1:0] i_mem_addr,
  input  logic [3:0]            i_mem_mask,
  input  logic [XLEN-1:0]       i_mem_wdata,
  output logic                  o_mem_gnt,
  output logic                  o_mem_rvalid,
  output logic [XLEN-1:0]       o_mem_rdata,
  output logic [ADDR_WIDTH-1:0] o_ram_addr,
  output logic                  o_ram_rd_en,
  output logic                  o_ram_wr_en,
  output logic [3:0]            o_ram_mask,
  output logic [XLEN-1:0]       o_ram_wdata,
  input  logic [XLEN-1:0]       i_ram_rd_data
);

  typedef enum logic [1:0] {
    ST_NONE,
    ST_IF_RD,
    ST_MEM_RD,
    ST_MEM_WR
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            w_if_win;
  logic [XLEN-1:0] r_if_rdata;
  logic [XLEN-1:0] r_mem_rdata;

`ifdef NNRV_MEM_ARB_STARVE_EN
  localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

  logic [CNT_W-1:0] r_starve_cnt;
  logic             w_starved;

  assign w_starved = (r_starve_cnt == CNT_W'(STARVE_LIMIT));
  assign w_if_win  = w_starved;

  // Counts denied IF cycles; saturates so promotion persists until IF is served.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_starve_cnt <= '0;
    end else if (!i_if_req || o_if_gnt) begin
      r_starve_cnt <= '0;
    end else if (!w_starved) begin
      r_starve_cnt <= r_starve_cnt + 1'b1;
    end
  end
`else
  logic w_unused_starve_limit;
  assign w_unused_starve_limit = (STARVE_LIMIT > 0);
  assign w_if_win              = 1'b0;
`endif

  // Grant and RAM command are combinational; reset forces the idle command.
  always_comb begin
    o_if_gnt    = 1'b0;
    o_mem_gnt   = 1'b0;
    o_ram_addr  = '0;
    o_ram_rd_en = 1'b0;
    o_ram_wr_en = 1'b0;
    o_ram_mask  = '0;
    o_ram_wdata = '0;
    w_state_nxt = ST_NONE;
    if (!i_rst) begin
      if (i_mem_req && !(i_if_req && w_if_win)) begin
        o_mem_gnt  = 1'b1;
        o_ram_addr = i_mem_addr;
        o_ram_mask = i_mem_mask;
        if (i_mem_we) begin
          o_ram_wr_en = 1'b1;
          o_ram_wdata = i_mem_wdata;
          w_state_nxt = ST_MEM_WR;
        end else begin
          o_ram_rd_en = 1'b1;
          w_state_nxt = ST_MEM_RD;
        end
      end else if (i_if_req) begin
        o_if_gnt    = 1'b1;
        o_ram_addr  = i_if_addr;
        o_ram_rd_en = 1'b1;
        o_ram_mask  = '1;
        w_state_nxt = ST_IF_RD;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= ST_NONE;
      r_if_rdata  <= '0;
      r_mem_rdata <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_IF_RD)  r_if_rdata  <= i_ram_rd_data;
      if (r_state == ST_MEM_RD) r_mem_rdata <= i_ram_rd_data;
    end
  end

  // Read data passes through in the return cycle, then the captured copy holds it.
  assign o_if_rvalid  = (r_state == ST_IF_RD);
  assign o_mem_rvalid = (r_state == ST_MEM_RD);
  assign o_if_rdata   = o_if_rvalid  ? i_ram_rd_data : r_if_rdata;
  assign o_mem_rdata  = o_mem_rvalid ? i_ram_rd_data : r_mem_rdata;

endmodule
